vecmat_dot_param: RTL and testbench
===================================

VECMAT_DOT_PARAM -- requirements
Module: vecmat_dot_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed fixed-point element width.
REQ-002 SHALL have parameter FRAC_W, default 8: fractional bits of every element, product and result.
REQ-003 SHALL have parameter LANES, default 32: elements per input beat; power of two, 2..64.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state.
REQ-006 SHALL have port vector, input, LANES*DATA_W bits: lane i at [i*DATA_W +: DATA_W].
REQ-007 SHALL have port matrix, input, LANES*DATA_W bits: same packing as vector.
REQ-008 SHALL have port in_valid, input, 1 bit: beat present.
REQ-009 SHALL have port in_last, input, 1 bit: the beat is the final chunk of a dot product.
REQ-010 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid && in_ready.
REQ-011 SHALL have port data_out, output, DATA_W bits: saturated dot-product result.
REQ-012 SHALL have port overflow, output, 1 bit: saturation occurred anywhere in this result.
REQ-013 SHALL have port out_valid, output, 1 bit: result present.
REQ-014 SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.

Function
REQ-015 Per lane: product = (vector_i * matrix_i) >>> FRAC_W (arithmetic shift, truncation toward -inf), saturated to DATA_W signed; saturation sets the result's overflow.
REQ-016 Lane products SHALL be summed by a binary tree of log2(LANES) levels at full width DATA_W+log2(LANES), no saturation inside the tree.
REQ-017 Pipeline registers SHALL sit after the products and after every second tree level (and after the final level if log2(LANES) is odd); one accumulator stage follows.
REQ-018 Latency SHALL be 1 + ceil(log2(LANES)/2) + 1 cycles from acceptance of the in_last beat to out_valid (5 for LANES=32), with no stall.
REQ-019 The accumulator, width DATA_W+log2(LANES)+8, SHALL add each beat's tree sum; on a beat with in_last it SHALL emit, then restart from zero for the next beat.
REQ-020 data_out SHALL be the accumulator value saturated to DATA_W signed ([-2^(DATA_W-1), 2^(DATA_W-1)-1]); saturation sets overflow.
REQ-021 overflow SHALL be sticky across all beats of one dot product and cleared when the next product starts.
REQ-022 Beats without in_last SHALL produce no out_valid.
REQ-023 Stall: when out_valid && !out_ready, the whole pipeline SHALL freeze and in_ready SHALL be 0; data_out and overflow SHALL be held stable.
REQ-024 in_ready SHALL equal !(out_valid && !out_ready); full throughput of one beat per cycle when not stalled.
REQ-025 Pipeline bubbles (in_valid=0) SHALL advance without affecting the accumulator.
REQ-026 out_valid SHALL deassert the cycle after the handshake unless a new result arrives in the same cycle.

Reset
REQ-027 On reset: out_valid=0, data_out=0, overflow=0; in_ready=1 once reset is released.
REQ-028 Reset mid-accumulation SHALL discard all partial sums and pipeline contents; no stale result SHALL ever appear.

Structure
REQ-029 Package vecmat_pkg SHALL hold clog2 helper, ACC_W and TREE_W derivation functions, and the saturate function.
REQ-030 One sub-module, vecmat_lane_mul (registered saturating fixed-point multiply with overflow flag), SHALL be instantiated LANES times via generate.

Verification (DATA_W=16, FRAC_W=8, LANES=32)
REQ-031 All lanes 0x0100 x 0x0200, one beat with in_last -> data_out=0x4000, overflow=0, out_valid exactly 5 cycles after acceptance.
REQ-032 All lanes 0x7FFF x 0x7FFF, one beat with in_last -> data_out=0x7FFF, overflow=1; lane 0 0xFF00 x 0x0100, others 0 -> 0xFF00, overflow=0.
REQ-033 Three consecutive beats, lane 0 0x0100 x 0x0100, others 0, in_last on beat 3 -> single result 0x0300.
REQ-034 Hold out_ready=0 while a result is pending -> in_ready=0, data_out stable; raise out_ready -> handshake once, streaming resumes with no lost or duplicated beats.
REQ-035 Assert reset after beat 1 of 3 -> out_valid=0 immediately; after release, one in_last beat of 0x0100 x 0x0100 on lane 0 -> 0x0100 (no residue).

Source files
------------

// File: rtl/vecmat_pkg.sv
// Shared sizing helpers and the signed saturation function for the
// vector-matrix dot-product datapath.
package vecmat_pkg;

  localparam int SAT_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int tree_w(input int data_w, input int lanes);
    return data_w + clog2(lanes);
  endfunction

  function automatic int acc_w(input int data_w, input int lanes);
    return data_w + clog2(lanes) + 8;
  endfunction

  // Clamp a wide signed value into a width-bit signed range; clipped flags the clamp.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                       input int width,
                                                       output logic clipped);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    clipped = 1'b0;
    res = value;
    if (value > hi) begin
      res = hi;
      clipped = 1'b1;
    end else if (value < lo) begin
      res = lo;
      clipped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/vecmat_lane_mul.sv
// One lane: registered signed fixed-point multiply, rescaled by FRAC_W and
// saturated back to DATA_W, with a registered saturation flag.
module vecmat_lane_mul
  import vecmat_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] product,
  output logic                     overflow
);

  logic signed [2*DATA_W-1:0] full;
  logic signed [DATA_W-1:0]   prod_d;
  logic                       ovf_d;

  always_comb begin
    ovf_d  = 1'b0;
    full   = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    prod_d = DATA_W'(saturate(SAT_W'(full >>> FRAC_W), DATA_W, ovf_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product  <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      product  <= prod_d;
      overflow <= ovf_d;
    end
  end

endmodule

// File: rtl/vecmat_dot_param.sv
// Streaming dot product: LANES saturating multipliers, a pipelined adder
// tree and a per-result accumulator with a sticky overflow flag.
module vecmat_dot_param
  import vecmat_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] vector,
  input  logic [LANES*DATA_W-1:0] matrix,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic                    overflow,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int LVLS   = clog2(LANES);
  localparam int TREE_W = tree_w(DATA_W, LANES);
  localparam int ACC_W  = acc_w(DATA_W, LANES);

  // A pending, unconsumed result freezes every stage at once.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  logic signed [DATA_W-1:0] lane_prod [LANES];
  logic [LANES-1:0]         lane_ovf;
  logic                     s0_vld;
  logic                     s0_lst;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vecmat_lane_mul #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W)
    ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .a       (vector[i*DATA_W +: DATA_W]),
      .b       (matrix[i*DATA_W +: DATA_W]),
      .product (lane_prod[i]),
      .overflow(lane_ovf[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_vld <= 1'b0;
      s0_lst <= 1'b0;
    end else if (en) begin
      s0_vld <= in_valid;
      s0_lst <= in_valid && in_last;
    end
  end

  // Level l holds LANES>>l partial sums; registers after even levels and the last one.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = LANES >> l;
    logic [N*TREE_W-1:0] node;
    logic                vld;
    logic                lst;
    logic                ovf;

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_ext
        assign node[j*TREE_W +: TREE_W] = TREE_W'(lane_prod[j]);
      end
      assign vld = s0_vld;
      assign lst = s0_lst;
      assign ovf = |lane_ovf;
    end else begin : g_node
      logic [N*TREE_W-1:0] sum;
      for (genvar j = 0; j < N; j++) begin : g_add
        assign sum[j*TREE_W +: TREE_W] = g_lvl[l-1].node[(2*j)*TREE_W +: TREE_W]
                                       + g_lvl[l-1].node[(2*j+1)*TREE_W +: TREE_W];
      end

      if ((l % 2 == 0) || (l == LVLS)) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            node <= '0;
            vld  <= 1'b0;
            lst  <= 1'b0;
            ovf  <= 1'b0;
          end else if (en) begin
            node <= sum;
            vld  <= g_lvl[l-1].vld;
            lst  <= g_lvl[l-1].lst;
            ovf  <= g_lvl[l-1].ovf;
          end
        end
      end else begin : g_comb
        assign node = sum;
        assign vld  = g_lvl[l-1].vld;
        assign lst  = g_lvl[l-1].lst;
        assign ovf  = g_lvl[l-1].ovf;
      end
    end
  end

  logic signed [TREE_W-1:0] tail_sum;
  logic                     tail_vld;
  logic                     tail_lst;
  logic                     tail_ovf;
  assign tail_sum = $signed(g_lvl[LVLS].node);
  assign tail_vld = g_lvl[LVLS].vld;
  assign tail_lst = g_lvl[LVLS].lst;
  assign tail_ovf = g_lvl[LVLS].ovf;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     acc_ovf;
  logic signed [DATA_W-1:0] result;
  logic                     sat_ovf;

  always_comb begin
    sat_ovf = 1'b0;
    acc_sum = acc + ACC_W'(tail_sum);
    result  = DATA_W'(saturate(SAT_W'(acc_sum), DATA_W, sat_ovf));
  end

  // The last beat emits the result and restarts the sum and sticky flag from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      out_valid <= tail_vld && tail_lst;
      if (tail_vld) begin
        if (tail_lst) begin
          data_out <= result;
          overflow <= acc_ovf || tail_ovf || sat_ovf;
          acc      <= '0;
          acc_ovf  <= 1'b0;
        end else begin
          acc     <= acc_sum;
          acc_ovf <= acc_ovf || tail_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_vecmat_dot_param.sv
// Directed self-checking bench for vecmat_dot_param (DATA_W=16, FRAC_W=8, LANES=32).
module tb_vecmat_dot_param;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int LANES  = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [LANES*DATA_W-1:0] vector;
  logic [LANES*DATA_W-1:0] matrix;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [DATA_W-1:0]       data_out;
  logic                    overflow;
  logic                    out_valid;
  logic                    out_ready;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int hs_count = 0;
  int hs_before;
  int accept_cycle = 0;

  vecmat_dot_param #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .LANES (LANES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .vector   (vector),
    .matrix   (matrix),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .data_out (data_out),
    .overflow (overflow),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (out_valid && out_ready) hs_count <= hs_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; drives one beat and returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] ma,
                               input bit all_lanes, input bit last);
    int t;
    for (int i = 0; i < LANES; i++) begin
      vector[i*DATA_W +: DATA_W] = (all_lanes || i == 0) ? va : 16'h0000;
      matrix[i*DATA_W +: DATA_W] = (all_lanes || i == 0) ? ma : 16'h0000;
    end
    in_valid = 1'b1;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    accept_cycle = cycle;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [15:0] exp_data,
                            input logic exp_ovf, input int exp_lat);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      checkOutput({tag, "_timeout"}, 32'(out_valid), 32'd1);
    end else begin
      checkOutput({tag, "_data"}, 32'(data_out), 32'(exp_data));
      checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      if (exp_lat > 0) checkOutput({tag, "_latency"}, 32'(cycle - accept_cycle), 32'(exp_lat));
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    vector    = '0;
    matrix    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // 32 lanes of 1.0 * 2.0 = 64.0
    applyStimulus(16'h0100, 16'h0200, 1'b1, 1'b1);
    waitResult("one_by_two", 16'h4000, 1'b0, 5);

    applyStimulus(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    waitResult("sat_max", 16'h7FFF, 1'b1, 5);

    applyStimulus(16'hFF00, 16'h0100, 1'b0, 1'b1);
    waitResult("neg_one", 16'hFF00, 1'b0, 5);

    hs_before = hs_count;
    applyStimulus(16'h0100, 16'h0100, 1'b0, 1'b0);
    applyStimulus(16'h0100, 16'h0100, 1'b0, 1'b0);
    applyStimulus(16'h0100, 16'h0100, 1'b0, 1'b1);
    waitResult("accum3", 16'h0300, 1'b0, 5);
    checkOutput("accum3_results", 32'(hs_count - hs_before), 32'd1);

    // Three results queued behind a stalled consumer
    out_ready = 1'b0;
    applyStimulus(16'h0100, 16'h0100, 1'b0, 1'b1);
    applyStimulus(16'h0200, 16'h0100, 1'b0, 1'b1);
    applyStimulus(16'h0300, 16'h0100, 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_data", 32'(data_out), 32'h0100);
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("stall_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_hold_data", 32'(data_out), 32'h0100);
    checkOutput("stall_hold_in_ready", 32'(in_ready), 32'd0);
    hs_before = hs_count;
    out_ready = 1'b1;
    waitResult("drain_a", 16'h0100, 1'b0, 0);
    waitResult("drain_b", 16'h0200, 1'b0, 0);
    waitResult("drain_c", 16'h0300, 1'b0, 0);
    repeat (8) @(negedge clk);
    checkOutput("drain_count", 32'(hs_count - hs_before), 32'd3);
    checkOutput("drain_idle", 32'(out_valid), 32'd0);

    // Reset in the middle of a dot product must leave no residue
    applyStimulus(16'h0100, 16'h0100, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(16'h0100, 16'h0100, 1'b0, 1'b1);
    waitResult("after_rst", 16'h0100, 1'b0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
